aes_sbox_arbiter: RTL and testbench

Shared S-box lookup engine for the AES core. It arbitrates one forward/inverse S-box datapath of `LANES` byte lanes among `NUM_REQ` requesters, for example key expansion (SubWord) and the round datapath (SubBytes/InvSubBytes). Arbitration is round-robin with valid/ready handshakes on both sides. Each requester has its own one-deep response register. The block sits between the AES round controllers and the package S-box tables.

---
 rtl/aes_sbox_arbiter_if.sv | 30 +++
 rtl/aes_sbox_arbiter.sv | 123 ++++++++++++
 tb/tb_aes_sbox_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_arbiter_if.sv
// Request/response bundle between AES round controllers and the shared S-box engine.
// Ports: req_valid/req_inv/req_data/req_ready (request side), rsp_valid/rsp_data/rsp_ready
// (per-requester response side), busy and lookup_count (status). Parameters must match the engine.
interface aes_sbox_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_inv;
  logic [NUM_REQ*LANES*8-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ*LANES*8-1:0] rsp_data;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic                       busy;
  logic [CNT_W-1:0]           lookup_count;

  // Requesters and response consumers.
  modport master (
    output req_valid, req_inv, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy, lookup_count
  );

  // The arbitrated S-box engine.
  modport slave (
    input  req_valid, req_inv, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy, lookup_count
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Round-robin shared forward/inverse AES S-box engine, LANES bytes per grant, NUM_REQ requesters.
// Latency: 1 cycle from handshake to rsp_valid; one grant per cycle aggregate.
// Backpressure: a requester whose response slot is full (and not draining) is skipped.
// Ports: clk, rst (sync, active-high), bus (slave modport: request, response and status signals).
module aes_sbox_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  aes_sbox_arbiter_if.slave bus
);
  localparam int W     = LANES * 8;
  localparam int PTR_W = $clog2(NUM_REQ);

  // Byte x lives at bits [(255-x)*8 +: 8]: the first listed byte is the most significant.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [10:0] off;
    off = {~b, 3'b000};
    sub_byte = inv ? INV_SBOX[off +: 8] : SBOX[off +: 8];
  endfunction

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ*W-1:0] rsp_data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] slot_free;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic [W-1:0]       sel_data;
  logic               sel_inv;
  logic [W-1:0]       lut_out;

  // A slot draining this cycle can accept a new result in the same cycle.
  assign slot_free = ~rsp_valid_q | bus.rsp_ready;
  assign elig      = bus.req_valid & slot_free;

  // First eligible index at or after ptr wins; reset masks every grant.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        win        = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
    if (rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  // Only the winner's word goes through the single shared datapath.
  assign sel_data = bus.req_data[win*W +: W];
  assign sel_inv  = bus.req_inv[win];

  always_comb begin
    lut_out = '0;
    for (int k = 0; k < LANES; k++) begin
      lut_out[8*k +: 8] = sub_byte(sel_data[8*k +: 8], sel_inv);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i]    <= 1'b1;
          rsp_data_q[i*W +: W] <= lut_out;
        end else if (bus.rsp_ready[i]) begin
          rsp_valid_q[i]    <= 1'b0;
        end
      end
      if (found) begin
        ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready    = grant;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.busy         = |rsp_valid_q;
  assign bus.lookup_count = cnt_q;
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: lookups, round-robin, backpressure, reset, saturation.
// A second instance with a 4-bit counter covers saturation.
module tb_aes_sbox_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_sbox_arbiter_if #(.NUM_REQ(2), .LANES(4), .CNT_W(16)) bus_m ();
  aes_sbox_arbiter_if #(.NUM_REQ(2), .LANES(4), .CNT_W(4))  bus_s ();

  aes_sbox_arbiter #(.NUM_REQ(2), .LANES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  aes_sbox_arbiter #(.NUM_REQ(2), .LANES(4), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_m.req_valid = 2'b11;
    bus_m.rsp_ready = 2'b00;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b00) begin
      errors++; $display("FAIL rst_req_ready got %b want 00", bus_m.req_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (bus_m.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL rst_rsp_valid got %b want 00", bus_m.rsp_valid);
    end
    checks++;
    if (bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", bus_m.busy);
    end
    checks++;
    if (bus_m.lookup_count !== 16'd0) begin
      errors++; $display("FAIL rst_count got %0d want 0", bus_m.lookup_count);
    end
    checks++;
    if (bus_m.rsp_data !== 64'd0) begin
      errors++; $display("FAIL rst_rsp_data got %h want 0", bus_m.rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_m.req_valid = 2'b00;
  endtask

  task automatic test_forward();
    @(negedge clk);
    bus_m.req_valid = 2'b01;
    bus_m.req_inv   = 2'b00;
    bus_m.req_data  = {32'h0, 32'h000153FF};
    bus_m.rsp_ready = 2'b00;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b01) begin
      errors++; $display("FAIL fwd_req_ready got %b want 01", bus_m.req_ready);
    end
    @(posedge clk); #1;
    bus_m.req_valid = 2'b00;
    checks++;
    if (bus_m.rsp_valid !== 2'b01) begin
      errors++; $display("FAIL fwd_rsp_valid got %b want 01", bus_m.rsp_valid);
    end
    checks++;
    if (bus_m.rsp_data[31:0] !== 32'h637CED16) begin
      errors++; $display("FAIL fwd_data got %h want 637ced16", bus_m.rsp_data[31:0]);
    end
    checks++;
    if (bus_m.lookup_count !== 16'd1) begin
      errors++; $display("FAIL fwd_count got %0d want 1", bus_m.lookup_count);
    end
    checks++;
    if (bus_m.busy !== 1'b1) begin
      errors++; $display("FAIL fwd_busy got %b want 1", bus_m.busy);
    end
  endtask

  task automatic test_inverse();
    @(negedge clk);
    bus_m.req_valid = 2'b10;
    bus_m.req_inv   = 2'b10;
    bus_m.req_data  = {32'h637CED16, 32'h0};
    bus_m.rsp_ready = 2'b00;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b10) begin
      errors++; $display("FAIL inv_req_ready got %b want 10", bus_m.req_ready);
    end
    @(posedge clk); #1;
    bus_m.req_valid = 2'b00;
    checks++;
    if (bus_m.rsp_data[63:32] !== 32'h000153FF) begin
      errors++; $display("FAIL inv_data got %h want 000153ff", bus_m.rsp_data[63:32]);
    end
    checks++;
    if (bus_m.rsp_data[31:0] !== 32'h637CED16) begin
      errors++; $display("FAIL inv_data0_kept got %h want 637ced16", bus_m.rsp_data[31:0]);
    end
    checks++;
    if (bus_m.rsp_valid !== 2'b11 || bus_m.lookup_count !== 16'd2) begin
      errors++; $display("FAIL inv_state got valid=%b count=%0d want valid=11 count=2",
                         bus_m.rsp_valid, bus_m.lookup_count);
    end
  endtask

  // Slot 0 is full and held; requester 1 drains and refills every cycle.
  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_m.req_valid = 2'b11;
      bus_m.req_inv   = 2'b00;
      bus_m.req_data  = {32'h00000000, 32'h53535353};
      bus_m.rsp_ready = 2'b10;
      #1;
      checks++;
      if (bus_m.req_ready !== 2'b10) begin
        errors++; $display("FAIL bp_req_ready[%0d] got %b want 10", i, bus_m.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_m.rsp_data[31:0] !== 32'h637CED16) begin
        errors++; $display("FAIL bp_hold0[%0d] got %h want 637ced16", i, bus_m.rsp_data[31:0]);
      end
      checks++;
      if (bus_m.rsp_data[63:32] !== 32'h63636363 || bus_m.rsp_valid !== 2'b11) begin
        errors++; $display("FAIL bp_rsp1[%0d] got %h/%b want 63636363/11",
                           i, bus_m.rsp_data[63:32], bus_m.rsp_valid);
      end
      checks++;
      if (bus_m.lookup_count !== 16'(3 + i)) begin
        errors++; $display("FAIL bp_count[%0d] got %0d want %0d", i, bus_m.lookup_count, 3 + i);
      end
    end
    @(negedge clk);
    bus_m.rsp_ready = 2'b11;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release got %b want 01", bus_m.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_m.rsp_data[31:0] !== 32'hEDEDEDED) begin
      errors++; $display("FAIL bp_release_data got %h want edededed", bus_m.rsp_data[31:0]);
    end
    checks++;
    if (bus_m.rsp_valid !== 2'b01 || bus_m.lookup_count !== 16'd6) begin
      errors++; $display("FAIL bp_release_state got valid=%b count=%0d want 01/6",
                         bus_m.rsp_valid, bus_m.lookup_count);
    end
    @(negedge clk);
    bus_m.req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    int g0;
    int g1;
    g0 = 0;
    g1 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_m.req_valid = 2'b11;
      bus_m.req_inv   = 2'b10;
      bus_m.req_data  = {32'h637CED16, 32'h000153FF};
      bus_m.rsp_ready = 2'b11;
      #1;
      checks++;
      if (bus_m.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus_m.req_ready,
                           (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (bus_m.req_ready[0]) g0++;
      if (bus_m.req_ready[1]) g1++;
      @(posedge clk);
    end
    #1;
    bus_m.req_valid = 2'b00;
    checks++;
    if (bus_m.lookup_count !== 16'd8) begin
      errors++; $display("FAIL rr_count got %0d want 8", bus_m.lookup_count);
    end
    checks++;
    if (g0 != 4 || g1 != 4) begin
      errors++; $display("FAIL rr_share got %0d/%0d want 4/4", g0, g1);
    end
    checks++;
    if (bus_m.rsp_data !== {32'h000153FF, 32'h637CED16} || bus_m.rsp_valid !== 2'b10) begin
      errors++; $display("FAIL rr_rsp got %h/%b want 000153ff637ced16/10",
                         bus_m.rsp_data, bus_m.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_m.req_valid = 2'b10;
    bus_m.rsp_ready = 2'b11;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b10) begin
      errors++; $display("FAIL rm_grant got %b want 10", bus_m.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus_m.req_valid = 2'b11;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b00) begin
      errors++; $display("FAIL rm_masked got %b want 00", bus_m.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_m.rsp_valid !== 2'b00 || bus_m.busy !== 1'b0 || bus_m.lookup_count !== 16'd0) begin
      errors++; $display("FAIL rm_cleared got valid=%b busy=%b count=%0d want 00/0/0",
                         bus_m.rsp_valid, bus_m.busy, bus_m.lookup_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus_m.req_ready !== 2'b01) begin
      errors++; $display("FAIL rm_first_winner got %b want 01", bus_m.req_ready);
    end
    @(posedge clk); #1;
    bus_m.req_valid = 2'b00;
    checks++;
    if (bus_m.rsp_valid !== 2'b01 || bus_m.lookup_count !== 16'd1) begin
      errors++; $display("FAIL rm_after got valid=%b count=%0d want 01/1",
                         bus_m.rsp_valid, bus_m.lookup_count);
    end
  endtask

  // Single requester at full rate into a 4-bit counter.
  task automatic test_saturation();
    int want;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus_s.req_valid = 2'b01;
      bus_s.req_inv   = 2'b00;
      bus_s.req_data  = {32'h0, 32'h000153FF};
      bus_s.rsp_ready = 2'b01;
      #1;
      checks++;
      if (bus_s.req_ready !== 2'b01) begin
        errors++; $display("FAIL sat_grant[%0d] got %b want 01", k, bus_s.req_ready);
      end
      @(posedge clk); #1;
      want = (k + 1 > 15) ? 15 : k + 1;
      checks++;
      if (bus_s.lookup_count !== 4'(want)) begin
        errors++; $display("FAIL sat_count[%0d] got %0d want %0d", k, bus_s.lookup_count, want);
      end
    end
    checks++;
    if (bus_s.rsp_data[31:0] !== 32'h637CED16 || bus_s.rsp_valid !== 2'b01) begin
      errors++; $display("FAIL sat_rsp got %h/%b want 637ced16/01",
                         bus_s.rsp_data[31:0], bus_s.rsp_valid);
    end
    @(negedge clk);
    bus_s.req_valid = 2'b00;
  endtask

  initial begin
    bus_m.req_valid = '0;
    bus_m.req_inv   = '0;
    bus_m.req_data  = '0;
    bus_m.rsp_ready = '0;
    bus_s.req_valid = '0;
    bus_s.req_inv   = '0;
    bus_s.req_data  = '0;
    bus_s.rsp_ready = '0;
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
